// File: rtl/bsg_mem_1rw1r_sync_mask_init.sv
// One read/write port plus one read port synchronous memory with lane write masks,
// a hardware init sequencer (reset or clear_i), read-data hold and write-first forwarding.
module bsg_mem_1rw1r_sync_mask_init #(
    parameter int                 width_p       = 8,
    parameter int                 els_p         = 1024,
    parameter int                 mask_width_p  = width_p / 8,
    parameter logic [width_p-1:0] init_val_p    = '0,
    localparam int                addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     clear_i,
    output logic                     ready_o,

    input  logic                     v0_i,
    input  logic                     w0_i,
    input  logic [mask_width_p-1:0]  w_mask0_i,
    input  logic [addr_width_lp-1:0] addr0_i,
    input  logic [width_p-1:0]       data0_i,
    output logic [width_p-1:0]       data0_o,

    input  logic                     v1_i,
    input  logic [addr_width_lp-1:0] addr1_i,
    output logic [width_p-1:0]       data1_o,

    output logic                     state_o
);

    localparam int                     lane_lp = width_p / mask_width_p;
    localparam logic [addr_width_lp:0] els_lp  = (addr_width_lp + 1)'(els_p);
    localparam logic [addr_width_lp-1:0] last_lp = addr_width_lp'(els_p - 1);

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

    state_e                   state_r;
    logic [addr_width_lp-1:0] cnt_r;
    logic [width_p-1:0]       mem [els_p];

    logic               accept, in_range0, in_range1;
    logic               wr0, rd0, rd1, collide;
    logic [width_p-1:0] old0, merged;

    // Handshake: a request on either port is accepted at a rising edge when its
    // valid is high, ready_o is high and clear_i is low; otherwise it is dropped.
    assign accept    = (state_r == READY) & ~clear_i;
    assign in_range0 = {1'b0, addr0_i} < els_lp;
    assign in_range1 = {1'b0, addr1_i} < els_lp;
    assign wr0       = accept & v0_i & w0_i & in_range0;
    assign rd0       = accept & v0_i & ~w0_i;
    assign rd1       = accept & v1_i;
    assign collide   = wr0 & (addr1_i == addr0_i);
    assign state_o   = state_r;

    // Masked merge of the addressed word; also the forwarded value on a collision.
    always_comb begin
        old0   = in_range0 ? mem[addr0_i] : '0;
        merged = old0;
        for (int i = 0; i < mask_width_p; i++) begin
            if (w_mask0_i[i]) begin
                merged[i*lane_lp +: lane_lp] = data0_i[i*lane_lp +: lane_lp];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (state_r == INIT) begin
            mem[cnt_r] <= init_val_p;
        end else if (wr0) begin
            mem[addr0_i] <= merged;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= INIT;
            cnt_r   <= '0;
            ready_o <= 1'b0;
            data0_o <= '0;
            data1_o <= '0;
        end else begin
            if (state_r == INIT) begin
                if (clear_i) begin
                    cnt_r <= '0;
                end else if (cnt_r == last_lp) begin
                    state_r <= READY;
                    ready_o <= 1'b1;
                    cnt_r   <= '0;
                end else begin
                    cnt_r <= cnt_r + addr_width_lp'(1);
                end
            end else if (clear_i) begin
                state_r <= INIT;
                ready_o <= 1'b0;
                cnt_r   <= '0;
            end

            if (rd0) begin
                data0_o <= in_range0 ? mem[addr0_i] : '0;
            end
            if (rd1) begin
                data1_o <= !in_range1 ? '0 : (collide ? merged : mem[addr1_i]);
            end
        end
    end

endmodule

// File: tb/tb_bsg_mem_1rw1r_sync_mask_init.sv
// Directed bench for bsg_mem_1rw1r_sync_mask_init: reference memory model plus
// per-port expected-read queues, immediate assertions at each comparison.
module tb_bsg_mem_1rw1r_sync_mask_init;

    localparam int          W  = 32;
    localparam int          N  = 16;
    localparam int          M  = 4;
    localparam int          AW = 4;
    localparam logic [31:0] IV = 32'hA5A5A5A5;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          clear = 1'b0;
    logic          ready;
    logic          v0 = 1'b0, w0 = 1'b0, v1 = 1'b0;
    logic [M-1:0]  mask0 = '0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [W-1:0]  wdata0 = '0;
    logic [W-1:0]  rdata0, rdata1;
    logic          state;

    bsg_mem_1rw1r_sync_mask_init #(
        .width_p(W), .els_p(N), .mask_width_p(M), .init_val_p(IV)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .clear_i(clear), .ready_o(ready),
        .v0_i(v0), .w0_i(w0), .w_mask0_i(mask0), .addr0_i(addr0),
        .data0_i(wdata0), .data0_o(rdata0),
        .v1_i(v1), .addr1_i(addr1), .data1_o(rdata1),
        .state_o(state)
    );

    always #5 clk = ~clk;

    int           pass_cnt = 0;
    int           total_cnt = 0;
    logic [W-1:0] exp0_q[$];
    logic [W-1:0] exp1_q[$];
    logic [W-1:0] model [N];
    logic [W-1:0] last0 = '0;
    logic [W-1:0] last1 = '0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_ready(input string tag, input logic exp);
        check(tag, {31'b0, ready}, {31'b0, exp});
    endtask

    function automatic logic [W-1:0] merge(input logic [W-1:0] old, input logic [W-1:0] d,
                                           input logic [M-1:0] m);
        logic [W-1:0] r;
        r = old;
        for (int i = 0; i < M; i++) begin
            if (m[i]) r[i*8 +: 8] = d[i*8 +: 8];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        v0 = 1'b0; w0 = 1'b0; v1 = 1'b0; clear = 1'b0; mask0 = '0;
    endtask

    task automatic model_init();
        for (int i = 0; i < N; i++) model[i] = IV;
    endtask

    task automatic drive_wr(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [M-1:0] m);
        v0 = 1'b1; w0 = 1'b1; addr0 = a; wdata0 = d; mask0 = m;
        model[a] = merge(model[a], d, m);
    endtask

    task automatic drive_rd0(input logic [AW-1:0] a);
        v0 = 1'b1; w0 = 1'b0; addr0 = a;
        exp0_q.push_back(model[a]);
    endtask

    task automatic drive_rd1(input logic [AW-1:0] a);
        v1 = 1'b1; addr1 = a;
        exp1_q.push_back(model[a]);
    endtask

    task automatic pop0(input string tag);
        if (exp0_q.size() == 0) begin
            total_cnt++;
            $error("FAIL %s observed=%h expected=<empty queue>", tag, rdata0);
        end else begin
            last0 = exp0_q.pop_front();
            check(tag, rdata0, last0);
        end
    endtask

    task automatic pop1(input string tag);
        if (exp1_q.size() == 0) begin
            total_cnt++;
            $error("FAIL %s observed=%h expected=<empty queue>", tag, rdata1);
        end else begin
            last1 = exp1_q.pop_front();
            check(tag, rdata1, last1);
        end
    endtask

    task automatic wait_init(input string tag);
        for (int i = 0; i < N; i++) begin
            tick();
            check_ready(tag, i == N - 1);
        end
    endtask

    initial begin
        model_init();
        #2 reset_n = 1'b0;
        tick();
        tick();
        check_ready("rst_ready", 1'b0);
        check("rst_data0", rdata0, '0);
        check("rst_data1", rdata1, '0);
        reset_n = 1'b1;

        // 1: init sequence, then port 1 sweep of every entry
        wait_init("init_ready");
        check("init_data0_zero", rdata0, '0);
        check("init_data1_zero", rdata1, '0);
        for (int a = 0; a < N; a++) begin
            drive_rd1(AW'(a));
            tick();
            pop1("sweep_rd1");
        end
        idle();
        check("sweep_data0_zero", rdata0, '0);

        // 2: masked write then read back on port 0
        drive_wr(4'd3, 32'h11223344, 4'b0101);
        tick();
        idle();
        check("wr_keeps_data0", rdata0, '0);
        drive_rd0(4'd3);
        tick();
        idle();
        pop0("mask_rd0");
        check("mask_rd0_const", rdata0, 32'hA522A544);

        // 3: write-first forwarding on a same-address collision
        drive_wr(4'd7, 32'hDEADBEEF, 4'b1111);
        drive_rd1(4'd7);
        tick();
        idle();
        pop1("coll_full");
        check("coll_full_const", rdata1, 32'hDEADBEEF);
        drive_wr(4'd9, 32'hDEADBEEF, 4'b0011);
        drive_rd1(4'd9);
        tick();
        idle();
        pop1("coll_part");
        check("coll_part_const", rdata1, 32'hA5A5BEEF);
        drive_rd0(4'd9);
        tick();
        idle();
        pop0("coll_array");

        // both ports reading one address; all-zero mask write
        drive_rd0(4'd3);
        drive_rd1(4'd3);
        tick();
        idle();
        pop0("dual_rd0");
        pop1("dual_rd1");
        drive_wr(4'd4, 32'h00000000, 4'b0000);
        tick();
        idle();
        drive_rd1(4'd4);
        tick();
        idle();
        pop1("zero_mask");

        // 4: data1 holds while port 0 rewrites the entry
        drive_rd1(4'd2);
        tick();
        idle();
        pop1("hold_first");
        for (int k = 0; k < 5; k++) begin
            drive_wr(4'd2, $urandom, M'($urandom_range(15, 1)));
            tick();
            check("hold_data1", rdata1, last1);
        end
        idle();
        drive_rd1(4'd2);
        tick();
        idle();
        pop1("hold_after");

        // 5: clear with a simultaneous write; requests during init are ignored
        v0 = 1'b1; w0 = 1'b1; addr0 = 4'd5; wdata0 = 32'h12345678; mask0 = 4'hF;
        clear = 1'b1;
        tick();
        idle();
        check_ready("clear_ready", 1'b0);
        model_init();
        for (int i = 0; i < N; i++) begin
            v1 = 1'b1; addr1 = AW'(i);
            v0 = 1'b1; w0 = (i % 2) == 0; addr0 = 4'd6; wdata0 = 32'h0; mask0 = 4'hF;
            tick();
            check_ready("clear_init_ready", i == N - 1);
            check("clear_hold_data1", rdata1, last1);
            check("clear_hold_data0", rdata0, last0);
        end
        idle();
        drive_rd1(4'd5);
        tick();
        idle();
        pop1("clear_addr5");
        drive_rd0(4'd6);
        tick();
        idle();
        pop0("clear_addr6");

        // 6: asynchronous reset at init counter 8
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_ready("clear2_ready", 1'b0);
        repeat (8) tick();
        reset_n = 1'b0;
        #1;
        check_ready("async_ready", 1'b0);
        check("async_data0", rdata0, '0);
        check("async_data1", rdata1, '0);
        tick();
        reset_n = 1'b1;
        model_init();
        wait_init("reinit_ready");
        check("reinit_data0", rdata0, '0);
        check("reinit_data1", rdata1, '0);
        drive_rd1(4'd7);
        tick();
        idle();
        pop1("reinit_addr7");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
